// File: rtl/if_fetch_queue.sv
// ---------------------------------------------------------------------------
// if_fetch_queue
//   Instruction-fetch front end between the PC and ID stages. Owns the fetch
//   PC, drives chip-enable/address into a combinational instruction ROM,
//   captures each returned word together with its PC into a DEPTH-entry
//   FIFO and presents the FIFO head to ID over a valid/ready handshake.
//   A redirect (taken branch/jump) flushes the FIFO and reloads the PC.
//
// Ports
//   clk          in   1   clock, rising-edge
//   rst_n        in   1   asynchronous reset, active-low
//   rom_ce       out  1   ROM chip enable, high only on cycles that push
//   rom_addr     out  32  ROM byte address (current fetch PC)
//   rom_inst     in   32  ROM data for rom_addr, same cycle
//   redirect     in   1   flush queue and load redirect_pc
//   redirect_pc  in   32  new fetch address (bits[1:0] forced to 0)
//   id_valid     out  1   head entry valid for ID
//   id_ready     in   1   ID accepts head this cycle
//   id_inst      out  32  head instruction (0 when queue is empty)
//   id_pc        out  32  head PC (0 when queue is empty)
// ---------------------------------------------------------------------------
module if_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        rom_ce,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_inst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [31:0]      pc_q, pc_d;
    logic             ce_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;

    logic [31:0] mem_inst_q [DEPTH];
    logic [31:0] mem_pc_q   [DEPTH];

    logic empty, full, push, pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));

    // Redirect masks id_valid so ID can never consume an entry that is
    // being flushed in the same cycle.
    assign id_valid = !empty && !redirect;
    assign pop      = id_valid && id_ready;
    // A full queue may still accept a word when the head leaves this cycle.
    assign push     = ce_q && !redirect && (!full || pop);

    assign rom_ce   = push;
    assign rom_addr = pc_q;

    assign id_inst  = empty ? 32'h0 : mem_inst_q[rd_ptr_q];
    assign id_pc    = empty ? 32'h0 : mem_pc_q[rd_ptr_q];

    always_comb begin
        pc_d     = pc_q;
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (redirect) begin
            pc_d     = {redirect_pc[31:2], 2'b00};
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (push) begin
                pc_d     = pc_q + 32'd4;     // wraps naturally at 2^32
                wr_ptr_d = wr_ptr_q + 1'b1;  // DEPTH is a power of two
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= RESET_PC;
            ce_q     <= 1'b0;
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            pc_q     <= pc_d;
            ce_q     <= 1'b1;  // fetching starts one edge after reset release
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    // Storage needs no reset: entries are only visible while count_q says so.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_inst_q[wr_ptr_q] <= rom_inst;
            mem_pc_q[wr_ptr_q]   <= pc_q;
        end
    end

endmodule

// File: tb/tb_if_fetch_queue.sv
module tb_if_fetch_queue;

    logic        clk;
    logic        rst_n;
    logic        rom_ce;
    logic [31:0] rom_addr;
    logic [31:0] rom_inst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_inst;
    logic [31:0] id_pc;

    int checks;
    int failures;

    if_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rom_ce      (rom_ce),
        .rom_addr    (rom_addr),
        .rom_inst    (rom_inst),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .id_valid    (id_valid),
        .id_ready    (id_ready),
        .id_inst     (id_inst),
        .id_pc       (id_pc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ROM content model: distinct word per address, ZeroWord when disabled.
    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    assign rom_inst = rom_ce ? rom_word(rom_addr) : 32'h0;

    // Holds reset for two cycles, releases it at a falling edge.
    task automatic do_reset(input logic ready);
        rst_n       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        id_ready    = ready;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; id_ready = 1'b1;
        #1;
        checks++; if (rom_ce !== 1'b0) begin failures++; $display("FAIL reset_rom_ce got=%b exp=0", rom_ce); end
        checks++; if (rom_addr !== 32'h0) begin failures++; $display("FAIL reset_rom_addr got=%h exp=0", rom_addr); end
        checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL reset_id_valid got=%b exp=0", id_valid); end
        checks++; if (id_inst !== 32'h0) begin failures++; $display("FAIL reset_id_inst got=%h exp=0", id_inst); end
        checks++; if (id_pc !== 32'h0) begin failures++; $display("FAIL reset_id_pc got=%h exp=0", id_pc); end
    endtask

    task automatic test_stream;
        do_reset(1'b1);
        #1;
        checks++; if (rom_ce !== 1'b0) begin failures++; $display("FAIL stream_no_fetch_before_enable rom_ce=%b exp=0", rom_ce); end
        @(negedge clk);
        checks++; if (rom_ce !== 1'b1 || rom_addr !== 32'h0) begin failures++; $display("FAIL stream_first_fetch ce=%b addr=%h exp ce=1 addr=0", rom_ce, rom_addr); end
        checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL stream_first_valid_early got=%b exp=0", id_valid); end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++; if (rom_addr !== 32'(4*(k+1))) begin failures++; $display("FAIL stream_addr k=%0d got=%h exp=%h", k, rom_addr, 32'(4*(k+1))); end
            checks++; if (id_valid !== 1'b1 || id_pc !== 32'(4*k) || id_inst !== rom_word(32'(4*k)))
                begin failures++; $display("FAIL stream_head k=%0d valid=%b pc=%h inst=%h exp valid=1 pc=%h inst=%h", k, id_valid, id_pc, id_inst, 32'(4*k), rom_word(32'(4*k))); end
        end
    endtask

    task automatic test_stall;
        do_reset(1'b0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checks++; if (id_pc !== 32'h0) begin failures++; $display("FAIL stall_id_pc cyc=%0d got=%h exp=0", k, id_pc); end
        end
        checks++; if (rom_ce !== 1'b0 || rom_addr !== 32'h10) begin failures++; $display("FAIL stall_full ce=%b addr=%h exp ce=0 addr=10", rom_ce, rom_addr); end
        checks++; if (id_valid !== 1'b1 || id_inst !== rom_word(32'h0)) begin failures++; $display("FAIL stall_head valid=%b inst=%h exp valid=1 inst=%h", id_valid, id_inst, rom_word(32'h0)); end
    endtask

    // Continues from the full queue left by test_stall.
    task automatic test_full_pop;
        id_ready = 1'b1;
        #1;
        checks++; if (rom_ce !== 1'b1 || rom_addr !== 32'h10) begin failures++; $display("FAIL fullpop_push ce=%b addr=%h exp ce=1 addr=10", rom_ce, rom_addr); end
        @(negedge clk);
        id_ready = 1'b0;
        #1;
        checks++; if (id_pc !== 32'h4 || id_inst !== rom_word(32'h4)) begin failures++; $display("FAIL fullpop_head pc=%h inst=%h exp pc=4 inst=%h", id_pc, id_inst, rom_word(32'h4)); end
        checks++; if (rom_ce !== 1'b0 || rom_addr !== 32'h14) begin failures++; $display("FAIL fullpop_still_full ce=%b addr=%h exp ce=0 addr=14", rom_ce, rom_addr); end
    endtask

    task automatic test_redirect;
        do_reset(1'b0);
        repeat (4) @(negedge clk);
        checks++; if (id_valid !== 1'b1 || rom_addr !== 32'hC) begin failures++; $display("FAIL redir_pre valid=%b addr=%h exp valid=1 addr=c", id_valid, rom_addr); end
        redirect = 1'b1; redirect_pc = 32'h103;
        #1;
        checks++; if (id_valid !== 1'b0 || rom_ce !== 1'b0) begin failures++; $display("FAIL redir_same_cycle valid=%b ce=%b exp 0 0", id_valid, rom_ce); end
        @(negedge clk);
        redirect = 1'b0; id_ready = 1'b1;
        #1;
        checks++; if (rom_addr !== 32'h100 || rom_ce !== 1'b1) begin failures++; $display("FAIL redir_new_pc addr=%h ce=%b exp addr=100 ce=1", rom_addr, rom_ce); end
        checks++; if (id_valid !== 1'b0 || id_pc !== 32'h0) begin failures++; $display("FAIL redir_flushed valid=%b pc=%h exp 0 0", id_valid, id_pc); end
        @(negedge clk);
        checks++; if (id_valid !== 1'b1 || id_pc !== 32'h100 || id_inst !== rom_word(32'h100))
            begin failures++; $display("FAIL redir_head valid=%b pc=%h inst=%h exp valid=1 pc=100 inst=%h", id_valid, id_pc, id_inst, rom_word(32'h100)); end
    endtask

    task automatic test_back_to_back;
        redirect = 1'b1; redirect_pc = 32'h200;
        @(negedge clk);
        redirect_pc = 32'h300;
        @(negedge clk);
        redirect = 1'b0;
        #1;
        checks++; if (rom_addr !== 32'h300 || id_valid !== 1'b0) begin failures++; $display("FAIL b2b_last_wins addr=%h valid=%b exp addr=300 valid=0", rom_addr, id_valid); end
        @(negedge clk);
        checks++; if (id_pc !== 32'h300) begin failures++; $display("FAIL b2b_head pc=%h exp=300", id_pc); end
    endtask

    task automatic test_wrap;
        logic [31:0] exp_a [4];
        exp_a = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4};
        id_ready = 1'b1;
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        @(negedge clk);
        redirect = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (rom_addr !== exp_a[i] || rom_ce !== 1'b1) begin failures++; $display("FAIL wrap_addr i=%0d addr=%h ce=%b exp addr=%h ce=1", i, rom_addr, rom_ce, exp_a[i]); end
            if (i > 0) begin
                checks++; if (id_pc !== exp_a[i-1]) begin failures++; $display("FAIL wrap_id_pc i=%0d got=%h exp=%h", i, id_pc, exp_a[i-1]); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_redirect_ce0;
        rst_n = 1'b0; id_ready = 1'b1; redirect = 1'b0;
        repeat (2) @(negedge clk);
        redirect = 1'b1; redirect_pc = 32'h41;
        rst_n = 1'b1;
        @(negedge clk);
        redirect = 1'b0;
        #1;
        checks++; if (rom_addr !== 32'h40 || rom_ce !== 1'b1 || id_valid !== 1'b0)
            begin failures++; $display("FAIL ce0_redirect addr=%h ce=%b valid=%b exp addr=40 ce=1 valid=0", rom_addr, rom_ce, id_valid); end
        @(negedge clk);
        checks++; if (id_pc !== 32'h40) begin failures++; $display("FAIL ce0_head pc=%h exp=40", id_pc); end
    endtask

    task automatic test_async_reset;
        do_reset(1'b0);
        repeat (4) @(negedge clk);
        checks++; if (id_valid !== 1'b1 || rom_ce !== 1'b1) begin failures++; $display("FAIL arst_pre valid=%b ce=%b exp 1 1", id_valid, rom_ce); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (id_valid !== 1'b0 || rom_ce !== 1'b0 || rom_addr !== 32'h0 || id_pc !== 32'h0)
            begin failures++; $display("FAIL arst_immediate valid=%b ce=%b addr=%h pc=%h exp all 0", id_valid, rom_ce, rom_addr, id_pc); end
        @(negedge clk);
        rst_n = 1'b1; id_ready = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (id_valid !== 1'b1 || id_pc !== 32'h0 || rom_addr !== 32'h4)
            begin failures++; $display("FAIL arst_restart valid=%b pc=%h addr=%h exp valid=1 pc=0 addr=4", id_valid, id_pc, rom_addr); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset;
        test_stream;
        test_stall;
        test_full_pop;
        test_redirect;
        test_back_to_back;
        test_wrap;
        test_redirect_ce0;
        test_async_reset;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
